// File: rtl/i2c_reg_ctrl.sv
// Byte-level I2C slave sequencer driving the LED register bus.
// Optional idle abort: define I2C_CTRL_TIMEOUT_EN.
package led_driver_pkg;
    localparam int ADDR_BITS     = 3;
    localparam int DATA_BITS     = 8;
    localparam int I2C_ADDR_BITS = 7;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_ADDR,
        CTRL_REG,
        CTRL_DATA
    } ctrl_state_t;
endpackage

module i2c_reg_ctrl
    import led_driver_pkg::*;
#(
    parameter logic [I2C_ADDR_BITS-1:0] DEV_ADDR = 7'h62,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_det,
    input  logic                 stop_det,
    input  logic                 rx_valid,
    input  logic [7:0]           rx_byte,
    input  logic                 tx_req,
    output logic                 ack,
    output logic [7:0]           tx_byte,
    output logic                 tx_valid,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 r_en,
    output logic                 w_en,
    inout  logic [DATA_BITS-1:0] data
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    ctrl_state_t          state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic                 ai_q, ai_d;
    logic                 rw_q, rw_d;
    logic                 ack_q, ack_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 r_en_q, r_en_d;
    logic                 w_en_q, w_en_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;

`ifdef I2C_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ai_d       = ai_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = 1'b0;
        addr_d     = addr_q;
        r_en_d     = 1'b0;
        w_en_d     = 1'b0;
        wdata_d    = wdata_q;
`ifdef I2C_CTRL_TIMEOUT_EN
        tmo_hit = 1'b0;
        tmo_d   = tmo_q;
        if (start_det || stop_det || rx_valid || tx_req) begin
            tmo_d = '0;
        end else if (state_q != CTRL_IDLE) begin
            tmo_hit = (tmo_q == TMO_MAX);
            if (!tmo_hit) tmo_d = tmo_q + 1'b1;
        end
`endif

        // A fetch issued last cycle always completes, even across stop/start.
        if (r_en_q) begin
            tx_byte_d  = data;
            tx_valid_d = 1'b1;
            if (ai_q) ptr_d = ptr_q + 1'b1;
        end

        if (stop_det) begin
            state_d = CTRL_IDLE;
            ack_d   = 1'b0;
        end else if (start_det) begin
            state_d = CTRL_ADDR;
`ifdef I2C_CTRL_TIMEOUT_EN
        end else if (tmo_hit) begin
            state_d = CTRL_IDLE;
            ack_d   = 1'b0;
`endif
        end else begin
            unique case (state_q)
                CTRL_IDLE: ;
                CTRL_ADDR: begin
                    if (rx_valid) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            ack_d   = 1'b1;
                            rw_d    = rx_byte[0];
                            state_d = rx_byte[0] ? CTRL_DATA : CTRL_REG;
                        end else begin
                            ack_d   = 1'b0;
                            state_d = CTRL_IDLE;
                        end
                    end
                end
                CTRL_REG: begin
                    if (rx_valid) begin
                        ptr_d   = rx_byte[ADDR_BITS-1:0];
                        ai_d    = rx_byte[7];
                        ack_d   = 1'b1;
                        state_d = CTRL_DATA;
                    end
                end
                CTRL_DATA: begin
                    if (!rw_q && rx_valid) begin
                        w_en_d  = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = rx_byte;
                        ack_d   = 1'b1;
                        if (ai_q) ptr_d = ptr_q + 1'b1;
                    end else if (rw_q && tx_req && !r_en_q) begin
                        r_en_d = 1'b1;
                        addr_d = ptr_q;
                    end
                end
                default: state_d = CTRL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CTRL_IDLE;
            ptr_q      <= '0;
            ai_q       <= 1'b0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            addr_q     <= '0;
            r_en_q     <= 1'b0;
            w_en_q     <= 1'b0;
            wdata_q    <= '0;
`ifdef I2C_CTRL_TIMEOUT_EN
            tmo_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ai_q       <= ai_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            addr_q     <= addr_d;
            r_en_q     <= r_en_d;
            w_en_q     <= w_en_d;
            wdata_q    <= wdata_d;
`ifdef I2C_CTRL_TIMEOUT_EN
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign ack      = ack_q;
    assign tx_byte  = tx_byte_q;
    assign tx_valid = tx_valid_q;
    assign addr     = addr_q;
    assign r_en     = r_en_q;
    assign w_en     = w_en_q;
    assign data     = w_en_q ? wdata_q : 'z;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Scoreboard bench for i2c_reg_ctrl: directed I2C byte sequences,
// expected ACKs and bus events queued by the driver, checked by a monitor.
module tb_i2c_reg_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_det = 1'b0;
    logic       stop_det = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_req = 1'b0;
    logic       ack;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic [2:0] addr;
    logic       r_en;
    logic       w_en;
    wire  [7:0] data;

    logic [7:0] mem [8];

    int vecs = 0;
    int errs = 0;

    localparam logic [1:0] K_W = 2'd0;
    localparam logic [1:0] K_R = 2'd1;
    localparam logic [1:0] K_T = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] a;
        logic [7:0] d;
    } ev_t;

    ev_t  bus_q [$];
    logic ack_q [$];
    logic rx_prev = 1'b0;

`ifdef I2C_CTRL_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 4096;
`endif

    always #5 clk = ~clk;

    i2c_reg_ctrl #(
        .DEV_ADDR(7'h62),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_det(start_det),
        .stop_det(stop_det),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .tx_req(tx_req),
        .ack(ack),
        .tx_byte(tx_byte),
        .tx_valid(tx_valid),
        .addr(addr),
        .r_en(r_en),
        .w_en(w_en),
        .data(data)
    );

    // Register file model: drives the bus while a read strobe is up.
    assign data = r_en ? mem[addr] : 'z;

    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'(i * 8'h11);
            mem[2] <= 8'h5A;
        end else if (w_en) begin
            mem[addr] <= data;
        end
    end

    task automatic check_ev(input logic [1:0] k, input logic [2:0] a,
                            input logic [7:0] d);
        ev_t e;
        vecs++;
        if (bus_q.size() == 0) begin
            errs++;
            $display("FAIL bus_extra: got kind=%0d addr=%0d byte=%02h, required none",
                     k, a, d);
        end else begin
            e = bus_q.pop_front();
            if (e.kind != k || (k != K_T && e.a != a) || (k != K_R && e.d != d)) begin
                errs++;
                $display("FAIL bus_event: got kind=%0d addr=%0d byte=%02h, required kind=%0d addr=%0d byte=%02h",
                         k, a, d, e.kind, e.a, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (rx_prev) begin
                vecs++;
                if (ack_q.size() == 0) begin
                    errs++;
                    $display("FAIL ack_extra: got ack=%0b, required none", ack);
                end else begin
                    logic ea;
                    ea = ack_q.pop_front();
                    if (ack !== ea) begin
                        errs++;
                        $display("FAIL ack: got %0b, required %0b", ack, ea);
                    end
                end
            end
            rx_prev = rx_valid;
            if (w_en && r_en) begin
                vecs++;
                errs++;
                $display("FAIL strobe_overlap: got w_en=1 r_en=1, required exclusive");
            end
            if (w_en) check_ev(K_W, addr, data);
            if (r_en) check_ev(K_R, addr, 8'h00);
            if (tx_valid) check_ev(K_T, 3'd0, tx_byte);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic exp_ack);
        ack_q.push_back(exp_ack);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic start;
        start_det = 1'b1;
        tick();
        start_det = 1'b0;
        tick();
    endtask

    task automatic stop;
        stop_det = 1'b1;
        tick();
        stop_det = 1'b0;
        tick();
    endtask

    task automatic treq;
        tx_req = 1'b1;
        tick();
        tx_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic exp_w(input logic [2:0] a, input logic [7:0] d);
        bus_q.push_back('{kind: K_W, a: a, d: d});
    endtask

    task automatic exp_rd(input logic [2:0] a, input logic [7:0] d);
        bus_q.push_back('{kind: K_R, a: a, d: 8'h00});
        bus_q.push_back('{kind: K_T, a: 3'd0, d: d});
    endtask

    task automatic chk_out(input string nm, input logic [7:0] got,
                           input logic [7:0] req);
        vecs++;
        if (got !== req) begin
            errs++;
            $display("FAIL %s: got %02h, required %02h", nm, got, req);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_out("rst_ack", {7'd0, ack}, 8'h00);
        chk_out("rst_tx_byte", tx_byte, 8'h00);
        chk_out("rst_tx_valid", {7'd0, tx_valid}, 8'h00);
        chk_out("rst_addr", {5'd0, addr}, 8'h00);
        chk_out("rst_r_en", {7'd0, r_en}, 8'h00);
        chk_out("rst_w_en", {7'd0, w_en}, 8'h00);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();

        // Auto-increment write from register 3; tx_req ignored in write mode.
        start();
        send(8'hC4, 1'b1);
        send(8'h83, 1'b1);
        exp_w(3'd3, 8'h11);
        send(8'h11, 1'b1);
        treq();
        exp_w(3'd4, 8'h22);
        send(8'h22, 1'b1);
        stop();

        // Pointer wrap 7 -> 0.
        start();
        send(8'hC4, 1'b1);
        send(8'h87, 1'b1);
        exp_w(3'd7, 8'hAA);
        send(8'hAA, 1'b1);
        exp_w(3'd0, 8'hBB);
        send(8'hBB, 1'b1);
        stop();

        // Fixed-pointer read via repeated START; rx ignored in read mode.
        start();
        send(8'hC4, 1'b1);
        send(8'h02, 1'b1);
        start();
        send(8'hC5, 1'b1);
        send(8'h99, 1'b1);
        exp_rd(3'd2, 8'h5A);
        treq();
        exp_rd(3'd2, 8'h5A);
        treq();
        stop();

        // Auto-increment read across the wrap.
        start();
        send(8'hC4, 1'b1);
        send(8'h86, 1'b1);
        start();
        send(8'hC5, 1'b1);
        exp_rd(3'd6, 8'h66);
        treq();
        exp_rd(3'd7, 8'hAA);
        treq();
        exp_rd(3'd0, 8'hBB);
        treq();

        // Repeated START to a foreign address: NACK, then bus ignored.
        start();
        send(8'hA0, 1'b0);
        send(8'h55, 1'b0);
        treq();
        stop();

`ifdef I2C_CTRL_TIMEOUT_EN
        start();
        send(8'hC4, 1'b1);
        repeat (TMO + 4) tick();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        stop();
`endif

        repeat (6) tick();
        vecs++;
        if (bus_q.size() != 0) begin
            errs++;
            $display("FAIL bus_pending: got %0d events outstanding, required 0",
                     bus_q.size());
        end
        vecs++;
        if (ack_q.size() != 0) begin
            errs++;
            $display("FAIL ack_pending: got %0d acks outstanding, required 0",
                     ack_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
